// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning the architectural HI/LO registers.
// Runs a 1-bit-per-cycle shift-add multiplier or restoring divider and stalls the pipe while busy.
module muldiv_ctrl #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] HILO_RST = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             flush,
  input  logic             mf_req,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opb_q;
  logic                 is_div_q;
  logic                 neg_res_q;
  logic                 neg_rem_q;
  logic                 dz_q;
  logic                 done_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic                 src_signed;
  logic                 src1_neg;
  logic                 src2_neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH+1:0]     div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic [WIDTH-1:0]     res_hi;
  logic [WIDTH-1:0]     res_lo;

  always_comb begin
    src_signed = (op == 3'd1) || (op == 3'd3);
    src1_neg   = src_signed & src1[WIDTH-1];
    src2_neg   = src_signed & src2[WIDTH-1];
    // The most negative value negates to itself and is then read as unsigned.
    a_mag      = src1_neg ? -src1 : src1;
    b_mag      = src2_neg ? -src2 : src2;

    // acc = {partial product, remaining multiplier bits}
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next   = {mul_sum, acc_q[WIDTH-1:1]};

    // acc = {remainder, dividend bits / quotient bits}; MSB of diff is the borrow.
    div_diff   = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, opb_q};
    div_next   = div_diff[WIDTH+1] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    prod_fix   = neg_res_q ? -acc_q : acc_q;
    quo_fix    = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix    = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    res_hi     = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    res_lo     = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= HILO_RST;
      lo_q      <= HILO_RST;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (op_valid && !flush) begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                is_div_q  <= op[1];
                neg_res_q <= src1_neg ^ src2_neg;
                neg_rem_q <= src1_neg;
                dz_q      <= op[1] & (b_mag == '0);
                cnt_q     <= CW'(WIDTH);
                state_q   <= StRun;
                if (op[1]) begin
                  opb_q <= b_mag;
                  // Divide by zero preloads the final magnitudes and then holds them.
                  acc_q <= (b_mag == '0) ? {a_mag, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, a_mag};
                end else begin
                  opb_q <= a_mag;
                  acc_q <= {{WIDTH{1'b0}}, b_mag};
                end
              end
              3'd4:    hi_q <= src1;
              3'd5:    lo_q <= src1;
              default: ;
            endcase
          end
        end
        StRun: begin
          if (flush) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            if (!dz_q) begin
              acc_q <= is_div_q ? div_next : mul_next;
            end
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              state_q <= StFix;
            end
          end
        end
        StFix: begin
          state_q <= StIdle;
          if (!flush) begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy  = (state_q != StIdle);
  assign stall = busy & (op_valid | mf_req);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected HI/LO pairs are queued at issue and
// compared when done pulses.
module tb_muldiv_ctrl;

  logic        clk;
  logic        resetn;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        mf_req;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  muldiv_ctrl #(
    .WIDTH    (32),
    .HILO_RST (32'h0)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .op_valid (op_valid),
    .op       (op),
    .src1     (src1),
    .src2     (src2),
    .flush    (flush),
    .mf_req   (mf_req),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: {hi, lo} for ops 0..3.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] am, bm, qm, rm, q, r;
    case (o)
      3'd0: p = {32'h0, a} * {32'h0, b};
      3'd1: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      default: begin
        am = (o == 3'd3 && a[31]) ? (32'h0 - a) : a;
        bm = (o == 3'd3 && b[31]) ? (32'h0 - b) : b;
        if (bm == 32'h0) begin
          qm = 32'hFFFF_FFFF;
          rm = am;
        end else begin
          qm = am / bm;
          rm = am % bm;
        end
        q = (o == 3'd3 && (a[31] ^ b[31])) ? (32'h0 - qm) : qm;
        r = (o == 3'd3 && a[31]) ? (32'h0 - rm) : rm;
        p = {r, q};
      end
    endcase
    return p;
  endfunction

  always @(negedge clk) begin
    if (resetn === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_done", {63'h0, done}, 64'h0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check_eq("result", {hi, lo}, e);
        m_hi = e[63:32];
        m_lo = e[31:0];
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) check_eq("idle_timeout", {63'h0, busy}, 64'h0);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [63:0] e);
    wait_idle();
    op_valid = 1'b1;
    op       = o;
    src1     = a;
    src2     = b;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  // Called at the negedge after the accepting edge; returns negedges until done.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    if (done !== 1'b1) check_eq("done_timeout", {63'h0, done}, 64'h1);
  endtask

  initial begin
    int cyc;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    resetn   = 1'b0;
    op_valid = 1'b0;
    op       = 3'd0;
    src1     = '0;
    src2     = '0;
    flush    = 1'b0;
    mf_req   = 1'b0;
    m_hi     = '0;
    m_lo     = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", {63'h0, busy}, 64'h0);
    check_eq("rst_done", {63'h0, done}, 64'h0);
    check_eq("rst_hilo", {hi, lo}, 64'h0);
    resetn = 1'b1;
    @(negedge clk);

    // Directed vectors with literal expectations
    issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFE_0000_0001);
    check_eq("busy_after_start", {63'h0, busy}, 64'h1);
    wait_done(cyc);
    check_eq("multu_latency", 64'(cyc), 64'd33);
    check_eq("busy_at_done", {63'h0, busy}, 64'h0);

    issue(3'd1, 32'hFFFF_FFFD, 32'd7, 1, 64'hFFFF_FFFF_FFFF_FFEB);
    wait_done(cyc);
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1, 64'hFFFF_FFFF_FFFF_FFFD);
    wait_done(cyc);
    check_eq("div_latency", 64'(cyc), 64'd33);
    issue(3'd2, 32'd5, 32'd0, 1, 64'h0000_0005_FFFF_FFFF);
    wait_done(cyc);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1, 64'h0000_0000_8000_0000);
    wait_done(cyc);

    // mthi / mtlo in idle
    issue(3'd4, 32'h0000_1234, 32'h0, 0, 64'h0);
    check_eq("mthi", {hi, lo}, {32'h0000_1234, m_lo});
    check_eq("mthi_no_busy", {62'h0, busy, done}, 64'h0);
    m_hi = 32'h0000_1234;
    issue(3'd5, 32'h0000_CAFE, 32'h0, 0, 64'h0);
    check_eq("mtlo", {hi, lo}, {m_hi, 32'h0000_CAFE});
    m_lo = 32'h0000_CAFE;

    // mtlo and mf_req while busy: stalled and ignored
    issue(3'd2, 32'd100, 32'd7, 1, 64'h0000_0002_0000_000E);
    op_valid = 1'b1;
    op       = 3'd5;
    src1     = 32'hDEAD_BEEF;
    #1;
    check_eq("stall_op", {63'h0, stall}, 64'h1);
    repeat (3) @(negedge clk);
    check_eq("mtlo_busy_ignored", {32'h0, lo}, {32'h0, m_lo});
    op_valid = 1'b0;
    mf_req   = 1'b1;
    #1;
    check_eq("stall_mf", {63'h0, stall}, 64'h1);
    @(negedge clk);
    mf_req = 1'b0;
    wait_done(cyc);
    @(negedge clk);
    check_eq("lo_after_busy_mtlo", {32'h0, lo}, 64'h0000_0000_0000_000E);

    // Flush at RUN cycle 10
    issue(3'd3, 32'd1000, 32'd3, 0, 64'h0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_busy", {63'h0, busy}, 64'h0);
    check_eq("flush_hilo", {hi, lo}, {m_hi, m_lo});
    repeat (40) @(negedge clk);
    check_eq("flush_hilo_late", {hi, lo}, {m_hi, m_lo});

    // Flushed mthi in idle is dropped
    op_valid = 1'b1;
    op       = 3'd4;
    src1     = 32'h5555_5555;
    flush    = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    flush    = 1'b0;
    check_eq("flush_mthi", {hi, lo}, {m_hi, m_lo});

    // Reset mid-RUN
    issue(3'd1, 32'd123, 32'd456, 0, 64'h0);
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    check_eq("rst_mid_busy", {62'h0, busy, done}, 64'h0);
    check_eq("rst_mid_hilo", {hi, lo}, 64'h0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    issue(3'd0, 32'd6, 32'd7, 1, 64'h0000_0000_0000_002A);
    wait_done(cyc);
    check_eq("post_rst_latency", 64'(cyc), 64'd33);

    // Back-to-back random ops scored against the model
    for (int i = 0; i < 12; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'h0 : (($urandom_range(0, 1) == 0) ? $urandom
                                                 : 32'($urandom_range(1, 20)));
      if (i % 4 == 0) ra = 32'h8000_0000;
      issue(ro, ra, rb, 1, model(ro, ra, rb));
      wait_done(cyc);
      check_eq("rand_latency", 64'(cyc), 64'd33);
    end
    @(negedge clk);
    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
